// File: rtl/restador_serial_4bit_if.sv
// Handshake and operand/result bundle for the bit-serial 4-bit subtractor.
// Optional macro: RESTADOR_OVF_EN adds the signed-overflow flag Ovf.
interface restador_serial_4bit_if #(
    parameter int N = 4
) ();
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bi;
    logic         busy;
    logic         done;
    logic [N-1:0] Dif;
    logic         Bout;
`ifdef RESTADOR_OVF_EN
    logic         Ovf;

    modport master (output start, A, B, Bi, input busy, done, Dif, Bout, Ovf);
    modport slave  (input start, A, B, Bi, output busy, done, Dif, Bout, Ovf);
`else
    modport master (output start, A, B, Bi, input busy, done, Dif, Bout);
    modport slave  (input start, A, B, Bi, output busy, done, Dif, Bout);
`endif
endinterface

// File: rtl/restador_serial_4bit.sv
// Bit-serial subtractor: Dif = A - B - Bi, one bit per clock, LSB first,
// using a single full-subtractor cell behind a start/done handshake.
// Optional macro: RESTADOR_OVF_EN adds a registered signed-overflow output Ovf.
module restador_serial_4bit #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    restador_serial_4bit_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit
    function automatic logic fs_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    // Full-subtractor borrow-out
    function automatic logic fs_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [N-1:0]   sa_r;
    logic [N-1:0]   sb_r;
    logic           br_r;
    logic [N-2:0]   res_r;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   dif_r;
    logic           bout_r;
    logic           busy_r;
    logic           done_r;
    logic           accept_s;
    logic           finish_s;
    logic           d_s;
    logic           br_next_s;
    logic [N-1:0]   res_shift_s;
`ifdef RESTADOR_OVF_EN
    logic           a_msb_r;
    logic           b_msb_r;
    logic           ovf_r;
`endif

    // Single subtractor cell and the result value with the new bit shifted in
    always_comb begin
        d_s         = fs_diff(sa_r[0], sb_r[0], br_r);
        br_next_s   = fs_borrow(sa_r[0], sb_r[0], br_r);
        res_shift_s = {d_s, res_r};
    end

    // Next-state logic plus capture/finish strobes
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(N - 1)) begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s  = CALC;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shifters, borrow, bit counter and held results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_r   <= '0;
            sb_r   <= '0;
            br_r   <= 1'b0;
            res_r  <= '0;
            cnt_r  <= '0;
            dif_r  <= '0;
            bout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef RESTADOR_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            busy_r <= (state_s == CALC);
            done_r <= (state_s == DONE);
            if (accept_s) begin
                sa_r  <= bus.A;
                sb_r  <= bus.B;
                br_r  <= bus.Bi;
                res_r <= '0;
                cnt_r <= '0;
`ifdef RESTADOR_OVF_EN
                a_msb_r <= bus.A[N-1];
                b_msb_r <= bus.B[N-1];
`endif
            end else if (state_r == CALC) begin
                sa_r  <= sa_r >> 1;
                sb_r  <= sb_r >> 1;
                br_r  <= br_next_s;
                res_r <= res_shift_s[N-1:1];
                cnt_r <= cnt_r + CW'(1);
                if (finish_s) begin
                    dif_r  <= res_shift_s;
                    bout_r <= br_next_s;
`ifdef RESTADOR_OVF_EN
                    // Final diff bit is the result MSB
                    ovf_r  <= (a_msb_r != b_msb_r) & (d_s != a_msb_r);
`endif
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Dif  = dif_r;
    assign bus.Bout = bout_r;
`ifdef RESTADOR_OVF_EN
    assign bus.Ovf  = ovf_r;
`endif

endmodule

// File: doc/restador_serial_4bit.md
Name: restador_serial_4bit

Overview:
Bit-serial subtractor computing Dif = A - B - Bi, one bit per clock, LSB first, over N cycles using a single full-subtractor cell.
- Counterpart to the parallel 4-bit ripple adder: same operand widths and carry/borrow chaining semantics, inverse operation, traded for area.
- Used by ALU control as a multi-cycle subtract unit behind a start/done handshake.

Parameters:
N, 4, operand and result width in bits (N >= 2)

Ports:
clk    input   1   system clock, all logic on rising edge
rst_n  input   1   synchronous reset, active-low
start  input   1   request; sampled only in IDLE or DONE
A      input   N   minuend, captured on accepted start
B      input   N   subtrahend, captured on accepted start
Bi     input   1   borrow-in, captured on accepted start
busy   output  1   high while in CALC
done   output  1   one-cycle pulse when result is valid
Dif    output  N   difference (A - B - Bi) mod 2^N, held until next accepted start
Bout   output  1   borrow-out, 1 when A < B + Bi (unsigned)

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n sampled low on a rising clk edge resets the block.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - Dif = 0, Bout = 0
  - internal shift registers and bit counter = 0
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 -> capture A, B and Bi into internal registers; cnt = 0; go to CALC.
  - start=0 -> stay in IDLE.
- CALC (busy=1), each cycle:
  - a = sa[0], b = sb[0], br = borrow register.
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - Shift sa and sb right by 1. Shift d into the MSB of the result shift register.
  - cnt increments.
  - When cnt == N-1: on this edge load Dif from the completed shift value, load Bout = br_next, go to DONE.
- DONE:
  - done = 1 for exactly this cycle; busy = 0.
  - start=1 -> accepted exactly as in IDLE (back-to-back operation), go to CALC.
  - start=0 -> go to IDLE.
- Latency and throughput:
  - start accepted at edge k -> done high in cycle k+N+1; Dif/Bout valid from the same edge.
  - Back-to-back throughput: one result per N+1 cycles.
- Dif and Bout change only on the CALC->DONE edge or on reset. They are stable through IDLE and through the next CALC.
- start while busy=1 is ignored: no capture, no queueing, operands not re-sampled.
- A, B and Bi may change freely after the capture edge.
- Reset mid-operation (rst_n low during CALC) aborts the operation: no done pulse, all outputs return to reset values on the next edge.
- Arithmetic: modulo 2^N. Bit-exact with {Bout, Dif} = {1'b0, A} - {1'b0, B} - Bi taken as (N+1)-bit two's complement, with Bout = MSB.
- Boundary: Bi=1 with A == B gives Dif = all ones, Bout = 1. A=0, B=0, Bi=0 gives Dif = 0, Bout = 0.

Optional Feature:
Macro: RESTADOR_OVF_EN
- Defined:
  - Adds output port Ovf (1 bit, after Bout): signed two's-complement overflow.
  - Ovf = (A[N-1] != B[N-1]) & (Dif[N-1] != A[N-1]), using the captured A and B.
  - Registered together with Dif on the CALC->DONE edge; held like Dif; reset 0.
  - Bi participates in the result but adds no separate overflow term.
- Not defined: port Ovf does not exist; no related logic.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles -> busy=0, done=0, Dif=0, Bout=0.
2. Basic: A=9, B=3, Bi=0, start pulse at edge k -> busy high for cycles k+1..k+4, done pulse in cycle k+5, Dif=6, Bout=0.
3. Borrow: A=3, B=9, Bi=0 -> Dif=4'hA, Bout=1. Then A=0, B=0, Bi=1 -> Dif=4'hF, Bout=1.
4. Ignore/back-to-back:
   - Start A=5, B=2; during CALC drive start=1 with A=1, B=1 -> ignored; result Dif=3.
   - Hold start=1 with A=8, B=8 during the DONE cycle -> new op accepted; second done 5 cycles later with Dif=0, Bout=0.
5. Reset mid-op: start A=15, B=1; drop rst_n for 1 cycle two cycles later -> no done pulse, outputs 0. Next op A=6, B=2 -> Dif=4.
6. RESTADOR_OVF_EN defined:
   - A=7, B=15 -> Dif=8, Bout=1, Ovf=1.
   - A=7, B=2 -> Dif=5, Ovf=0.
   - Compile without the macro -> elaborates with no Ovf port.
